// File: rtl/rr_two_one_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// rr_two_one_arbiter_pkg
//   Shared definitions for the round-robin 2:1 arbiter:
//     - arb_state_e : FSM state encoding (ARB_IDLE=0, ARB_G0=1, ARB_G1=2)
//     - beat_cnt_w(): width of the per-grant beat counter, clog2(BURST_LEN)
//                     with a floor of 1 bit so BURST_LEN=1 still has a counter
// -----------------------------------------------------------------------------
package rr_two_one_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_G0   = 2'd1,
        ARB_G1   = 2'd2
    } arb_state_e;

    function automatic int beat_cnt_w(input int burst_len);
        return (burst_len > 1) ? $clog2(burst_len) : 1;
    endfunction

endpackage

// File: rtl/rr_two_one_arbiter_out_reg.sv
// -----------------------------------------------------------------------------
// arb_out_reg
//   Output register of the arbiter. It captures the winning beat and its
//   source index, and holds both stable while the downstream stalls.
//   Ports:
//     clk, rst_n    clock, synchronous active-low reset
//     load          a source transfer happens this cycle
//     load_data     data of the transferring source
//     load_sel      index (0/1) of the transferring source
//     out_ready     downstream accepts the held beat
//     out_valid     a beat is held
//     out_data      held data
//     selector      held source index, drives the downstream mux select
// -----------------------------------------------------------------------------
module arb_out_reg #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [DATA_W-1:0] load_data,
    input  logic              load_sel,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              selector
);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the values that existed before this clock edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            selector  <= 1'b0;
        end else if (load) begin
            out_valid <= 1'b1;
            out_data  <= load_data;
            selector  <= load_sel;
        end else if (out_ready) begin
            // Held beat consumed; data/selector keep their last value.
            out_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/rr_two_one_arbiter.sv
// -----------------------------------------------------------------------------
// rr_two_one_arbiter
//   Round-robin arbiter between two valid/ready sources feeding a 2:1 mux.
//   A source is granted for a burst of up to BURST_LEN beats; the winning
//   beat is registered together with its source index (selector).
//   Optional feature macro: ARB_STATS_EN adds saturating per-source transfer
//   counters grant_cnt0/grant_cnt1.
//   Ports:
//     clk, rst_n              clock, synchronous active-low reset
//     in0_valid/data/ready    source 0 handshake
//     in1_valid/data/ready    source 1 handshake
//     out_valid/data          registered winning beat
//     selector                registered source index of out_data
//     out_ready               downstream accepts beat
//     grant_cnt0/grant_cnt1   transfer counts (ARB_STATS_EN only)
// -----------------------------------------------------------------------------
module rr_two_one_arbiter
    import rr_two_one_arbiter_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int BURST_LEN = 4,
    parameter int STAT_W    = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in0_valid,
    input  logic [DATA_W-1:0] in0_data,
    output logic              in0_ready,
    input  logic              in1_valid,
    input  logic [DATA_W-1:0] in1_data,
    output logic              in1_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              selector,
    input  logic              out_ready
`ifdef ARB_STATS_EN
   ,output logic [STAT_W-1:0] grant_cnt0,
    output logic [STAT_W-1:0] grant_cnt1
`endif
);

    localparam int             BCW       = beat_cnt_w(BURST_LEN);
    localparam logic [BCW-1:0] LAST_BEAT = BCW'(BURST_LEN - 1);

    if (BURST_LEN < 1 || STAT_W < 1) begin : g_bad_param
        $error("rr_two_one_arbiter: BURST_LEN and STAT_W must be >= 1");
    end

    arb_state_e     state, state_nxt;
    logic           last_grant;
    logic [BCW-1:0] beat_cnt;
    logic           grant_entry;
    logic           can_accept;
    logic           xfer0, xfer1, xfer;
    logic           burst_done;

    // Ready never looks at the source's own valid, and is forced low in reset.
    assign can_accept = !out_valid || out_ready;
    assign in0_ready  = rst_n && (state == ARB_G0) && can_accept;
    assign in1_ready  = rst_n && (state == ARB_G1) && can_accept;

    assign xfer0      = in0_valid && in0_ready;
    assign xfer1      = in1_valid && in1_ready;
    assign xfer       = xfer0 || xfer1;
    assign burst_done = xfer && (beat_cnt == LAST_BEAT);

    // NOTE: every signal written here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_nxt   = state;
        grant_entry = 1'b0;
        case (state)
            ARB_IDLE: begin
                grant_entry = in0_valid || in1_valid;
                if (in0_valid && in1_valid)
                    state_nxt = last_grant ? ARB_G0 : ARB_G1;
                else if (in0_valid)
                    state_nxt = ARB_G0;
                else if (in1_valid)
                    state_nxt = ARB_G1;
            end
            ARB_G0: begin
                // A finished burst always re-grants: the transferring source
                // is valid by definition, so IDLE is never the outcome here.
                if (burst_done) begin
                    grant_entry = 1'b1;
                    state_nxt   = in1_valid ? ARB_G1 : ARB_G0;
                end else if (!in0_valid) begin
                    grant_entry = in1_valid;
                    state_nxt   = in1_valid ? ARB_G1 : ARB_IDLE;
                end
            end
            ARB_G1: begin
                if (burst_done) begin
                    grant_entry = 1'b1;
                    state_nxt   = in0_valid ? ARB_G0 : ARB_G1;
                end else if (!in1_valid) begin
                    grant_entry = in0_valid;
                    state_nxt   = in0_valid ? ARB_G0 : ARB_IDLE;
                end
            end
            default: state_nxt = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= ARB_IDLE;
            last_grant <= 1'b1;    // source 0 wins the first tie
            beat_cnt   <= '0;
        end else begin
            state <= state_nxt;
            if (grant_entry) begin
                beat_cnt   <= '0;
                last_grant <= (state_nxt == ARB_G1);
            end else if (xfer) begin
                beat_cnt <= beat_cnt + 1'b1;
            end
        end
    end

    arb_out_reg #(
        .DATA_W (DATA_W)
    ) u_out_reg (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (xfer),
        .load_data (xfer1 ? in1_data : in0_data),
        .load_sel  (xfer1),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .selector  (selector)
    );

`ifdef ARB_STATS_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            grant_cnt0 <= '0;
            grant_cnt1 <= '0;
        end else begin
            if (xfer0 && (grant_cnt0 != '1)) grant_cnt0 <= grant_cnt0 + 1'b1;
            if (xfer1 && (grant_cnt1 != '1)) grant_cnt1 <= grant_cnt1 + 1'b1;
        end
    end
`endif

endmodule
